// File: rtl/timing_gen_if.sv
// Timing generator bus: halt request in, clocks, phase strobes and status out.
interface timing_gen_if;
    logic halt_req;
    logic clk1;
    logic clk2;
    logic a12;
    logic a22;
    logic a32;
    logic m12;
    logic m22;
    logic x12;
    logic x22;
    logic x32;
    logic x21_clk2;
    logic x31_clk2;
    logic sync;
    logic poc;
    logic halted;

    modport master (
        input  halt_req,
        output clk1, clk2,
        output a12, a22, a32, m12, m22, x12, x22, x32,
        output x21_clk2, x31_clk2, sync, poc, halted
    );

    modport slave (
        output halt_req,
        input  clk1, clk2,
        input  a12, a22, a32, m12, m22, x12, x22, x32,
        input  x21_clk2, x31_clk2, sync, poc, halted
    );
endinterface

// File: rtl/timing_gen.sv
// Master timing generator: two-phase clocks, phase strobes, SYNC, stretched
// power-on clear and a debug halt at instruction-cycle boundaries.
module timing_gen #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned POC_CYCLES = 8
) (
    input  logic          sysclk,
    input  logic          poc_n,
    timing_gen_if.master  bus
);
    localparam int unsigned DIV_W = 4;
    localparam int unsigned Q_W   = 2;
    localparam int unsigned POC_W = 8;
    localparam int unsigned CNT_W = POC_W + 1;
    localparam int unsigned STB_W = 8;

    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] POC_LIMIT = CNT_W'(POC_CYCLES);

    typedef enum logic [2:0] {
        PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
    } phase_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic [Q_W-1:0]   qtr_q, qtr_d;
    phase_t           ph_q, ph_d;
    logic [POC_W-1:0] poc_cnt_q, poc_cnt_d;
    logic             poc_q, poc_d;
    logic             halted_q, halted_d;
    // run_q marks that the edge leaving the reset-held X3 has passed, so that
    // edge is not counted as a completed instruction cycle.
    logic             run_q, run_d;

    logic             cycle_end;
    logic             wrap;

    logic             clk1_q, clk1_d;
    logic             clk2_q, clk2_d;
    logic [STB_W-1:0] strb_q, strb_d;
    logic             x21_q, x21_d;
    logic             x31_q, x31_d;
    logic             sync_q, sync_d;

    // Next counter state, halt/poc control, and outputs decoded from the next state.
    always_comb begin
        div_d     = div_q;
        qtr_d     = qtr_q;
        ph_d      = ph_q;
        poc_cnt_d = poc_cnt_q;
        poc_d     = poc_q;
        halted_d  = halted_q;
        run_d     = 1'b1;
        wrap      = 1'b0;
        cycle_end = (div_q == DIV_MAX) && (qtr_q == Q_W'(3)) && (ph_q == PH_X3);

        if (halted_q) begin
            if (!bus.halt_req) begin
                halted_d = 1'b0;
                div_d    = '0;
                qtr_d    = '0;
                ph_d     = PH_A1;
                wrap     = 1'b1;
            end
        end else if (cycle_end && bus.halt_req && !poc_q) begin
            halted_d = 1'b1;
        end else begin
            wrap = cycle_end;
            if (div_q == DIV_MAX) begin
                div_d = '0;
                qtr_d = qtr_q + Q_W'(1);
                if (qtr_q == Q_W'(3)) begin
                    ph_d = phase_t'(ph_q + 3'd1);
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        if (wrap && run_q && poc_q) begin
            if (poc_cnt_q != '1) begin
                poc_cnt_d = poc_cnt_q + POC_W'(1);
            end
            if ((CNT_W'(poc_cnt_q) + CNT_W'(1)) >= POC_LIMIT) begin
                poc_d = 1'b0;
            end
        end

        clk1_d = (qtr_d == Q_W'(0));
        clk2_d = (qtr_d == Q_W'(2));
        strb_d = '0;
        if (qtr_d == Q_W'(2)) begin
            strb_d[ph_d] = 1'b1;
        end
        x21_d  = (ph_d != PH_X2);
        x31_d  = (ph_d != PH_X3);
        sync_d = (ph_d == PH_X3);
    end

    // State and output registers; poc_n aborts to the power-on values at once.
    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            div_q     <= DIV_MAX;
            qtr_q     <= Q_W'(3);
            ph_q      <= PH_X3;
            poc_cnt_q <= '0;
            poc_q     <= 1'b1;
            halted_q  <= 1'b0;
            run_q     <= 1'b0;
            clk1_q    <= 1'b0;
            clk2_q    <= 1'b0;
            strb_q    <= '0;
            x21_q     <= 1'b1;
            x31_q     <= 1'b1;
            sync_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            ph_q      <= ph_d;
            poc_cnt_q <= poc_cnt_d;
            poc_q     <= poc_d;
            halted_q  <= halted_d;
            run_q     <= run_d;
            clk1_q    <= clk1_d;
            clk2_q    <= clk2_d;
            strb_q    <= strb_d;
            x21_q     <= x21_d;
            x31_q     <= x31_d;
            sync_q    <= sync_d;
        end
    end

    assign bus.clk1     = clk1_q;
    assign bus.clk2     = clk2_q;
    assign bus.a12      = strb_q[0];
    assign bus.a22      = strb_q[1];
    assign bus.a32      = strb_q[2];
    assign bus.m12      = strb_q[3];
    assign bus.m22      = strb_q[4];
    assign bus.x12      = strb_q[5];
    assign bus.x22      = strb_q[6];
    assign bus.x32      = strb_q[7];
    assign bus.x21_clk2 = x21_q;
    assign bus.x31_clk2 = x31_q;
    assign bus.sync     = sync_q;
    assign bus.poc      = poc_q;
    assign bus.halted   = halted_q;
endmodule

// File: tb/tb_timing_gen.sv
// Bench for timing_gen: four instances with different CLK_DIV/POC_CYCLES,
// a vector table for waveform shape plus sequences for halt and reset abort.
module tb_timing_gen;
    logic       sysclk = 1'b0;
    logic [3:0] rstn   = 4'hF;
    logic [3:0] hreq   = 4'h0;
    int         k;
    int         total  = 0;
    int         bad    = 0;

    always #5 sysclk = ~sysclk;

    timing_gen_if b0 ();
    timing_gen_if b1 ();
    timing_gen_if b2 ();
    timing_gen_if b3 ();

    assign b0.halt_req = hreq[0];
    assign b1.halt_req = hreq[1];
    assign b2.halt_req = hreq[2];
    assign b3.halt_req = hreq[3];

    timing_gen #(.CLK_DIV(1),  .POC_CYCLES(2)) u0 (.sysclk(sysclk), .poc_n(rstn[0]), .bus(b0));
    timing_gen #(.CLK_DIV(2),  .POC_CYCLES(1)) u1 (.sysclk(sysclk), .poc_n(rstn[1]), .bus(b1));
    timing_gen #(.CLK_DIV(1),  .POC_CYCLES(3)) u2 (.sysclk(sysclk), .poc_n(rstn[2]), .bus(b2));
    timing_gen #(.CLK_DIV(15), .POC_CYCLES(1)) u3 (.sysclk(sysclk), .poc_n(rstn[3]), .bus(b3));

    // {clk1, clk2, x32..a12, x21_clk2, x31_clk2, sync, poc, halted}
    logic [14:0] obs [4];
    assign obs[0] = {b0.clk1, b0.clk2, b0.x32, b0.x22, b0.x12, b0.m22, b0.m12, b0.a32, b0.a22, b0.a12,
                     b0.x21_clk2, b0.x31_clk2, b0.sync, b0.poc, b0.halted};
    assign obs[1] = {b1.clk1, b1.clk2, b1.x32, b1.x22, b1.x12, b1.m22, b1.m12, b1.a32, b1.a22, b1.a12,
                     b1.x21_clk2, b1.x31_clk2, b1.sync, b1.poc, b1.halted};
    assign obs[2] = {b2.clk1, b2.clk2, b2.x32, b2.x22, b2.x12, b2.m22, b2.m12, b2.a32, b2.a22, b2.a12,
                     b2.x21_clk2, b2.x31_clk2, b2.sync, b2.poc, b2.halted};
    assign obs[3] = {b3.clk1, b3.clk2, b3.x32, b3.x22, b3.x12, b3.m22, b3.m12, b3.a32, b3.a22, b3.a12,
                     b3.x21_clk2, b3.x31_clk2, b3.sync, b3.poc, b3.halted};

    typedef struct {
        int          inst;
        int          k;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl [$];

    function automatic logic [14:0] ev(logic c1, logic c2, logic [7:0] s, logic x21,
                                       logic x31, logic sy, logic pc, logic h);
        return {c1, c2, s, x21, x31, sy, pc, h};
    endfunction

    function automatic vec_t mk(int inst, int kk, logic [14:0] e);
        vec_t v;
        v.inst = inst;
        v.k    = kk;
        v.exp  = e;
        return v;
    endfunction

    task automatic check(string nm, logic [14:0] got, logic [14:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", nm, got, exp);
        end
    endtask

    task automatic check_n(string nm, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
        k++;
    endtask

    task automatic run_to(int n);
        while (k < n) tick();
    endtask

    task automatic do_release(int i);
        @(posedge sysclk);
        #1;
        rstn[i] = 1'b1;
        k = 0;
    endtask

    task automatic apply_tbl(int inst);
        foreach (tbl[n]) begin
            if (tbl[n].inst == inst) begin
                run_to(tbl[n].k);
                check($sformatf("u%0d k=%0d", inst, tbl[n].k), obs[inst], tbl[n].exp);
            end
        end
    endtask

    logic [14:0] RST, Q0, Q1, X3Q3, X3Q3_P0, A1_P0, X3_HALT;

    initial begin
        int sc [8];
        int x21_lo, x31_lo, both, multi;

        RST     = ev(0, 0, 8'h00, 1, 1, 0, 1, 0);
        Q0      = ev(1, 0, 8'h00, 1, 1, 0, 1, 0);
        Q1      = ev(0, 0, 8'h00, 1, 1, 0, 1, 0);
        X3Q3    = ev(0, 0, 8'h00, 1, 0, 1, 1, 0);
        X3Q3_P0 = ev(0, 0, 8'h00, 1, 0, 1, 0, 0);
        A1_P0   = ev(1, 0, 8'h00, 1, 1, 0, 0, 0);
        X3_HALT = ev(0, 0, 8'h00, 1, 0, 1, 0, 1);

        // CLK_DIV=1, POC_CYCLES=2
        tbl.push_back(mk(0, 0,  RST));
        tbl.push_back(mk(0, 1,  Q0));
        tbl.push_back(mk(0, 2,  Q1));
        tbl.push_back(mk(0, 3,  ev(0, 1, 8'h01, 1, 1, 0, 1, 0)));
        tbl.push_back(mk(0, 4,  Q1));
        tbl.push_back(mk(0, 7,  ev(0, 1, 8'h02, 1, 1, 0, 1, 0)));
        tbl.push_back(mk(0, 15, ev(0, 1, 8'h08, 1, 1, 0, 1, 0)));
        tbl.push_back(mk(0, 25, ev(1, 0, 8'h00, 0, 1, 0, 1, 0)));
        tbl.push_back(mk(0, 27, ev(0, 1, 8'h40, 0, 1, 0, 1, 0)));
        tbl.push_back(mk(0, 29, ev(1, 0, 8'h00, 1, 0, 1, 1, 0)));
        tbl.push_back(mk(0, 31, ev(0, 1, 8'h80, 1, 0, 1, 1, 0)));
        tbl.push_back(mk(0, 32, X3Q3));
        tbl.push_back(mk(0, 33, Q0));
        tbl.push_back(mk(0, 64, X3Q3));
        tbl.push_back(mk(0, 65, A1_P0));
        tbl.push_back(mk(0, 66, ev(0, 0, 8'h00, 1, 1, 0, 0, 0)));
        // CLK_DIV=15, POC_CYCLES=1
        tbl.push_back(mk(3, 1,   Q0));
        tbl.push_back(mk(3, 15,  Q0));
        tbl.push_back(mk(3, 16,  Q1));
        tbl.push_back(mk(3, 30,  Q1));
        tbl.push_back(mk(3, 31,  ev(0, 1, 8'h01, 1, 1, 0, 1, 0)));
        tbl.push_back(mk(3, 45,  ev(0, 1, 8'h01, 1, 1, 0, 1, 0)));
        tbl.push_back(mk(3, 46,  Q1));
        tbl.push_back(mk(3, 61,  Q0));
        tbl.push_back(mk(3, 421, ev(1, 0, 8'h00, 1, 0, 1, 1, 0)));
        tbl.push_back(mk(3, 480, X3Q3));
        tbl.push_back(mk(3, 481, A1_P0));

        #1 rstn = 4'h0;
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("reset u%0d", i), obs[i], RST);

        do_release(0);
        apply_tbl(0);

        do_release(3);
        apply_tbl(3);

        // CLK_DIV=2 free-running cycle statistics
        do_release(1);
        run_to(64);
        check("u1 poc before", obs[1], X3Q3);
        tick();
        check("u1 poc fall", obs[1], ev(1, 0, 8'h00, 1, 1, 0, 0, 0));
        foreach (sc[i]) sc[i] = 0;
        x21_lo = 0; x31_lo = 0; both = 0; multi = 0;
        for (int n = 0; n < 64; n++) begin
            if (n > 0) tick();
            for (int s = 0; s < 8; s++) sc[s] += int'(obs[1][5 + s]);
            x21_lo += int'(!obs[1][4]);
            x31_lo += int'(!obs[1][3]);
            both   += int'(obs[1][14] && obs[1][13]);
            multi  += int'($countones(obs[1][12:5]) > 1);
        end
        for (int s = 0; s < 8; s++) check_n($sformatf("strobe%0d width", s), sc[s], 2);
        check_n("x21 low width", x21_lo, 8);
        check_n("x31 low width", x31_lo, 8);
        check_n("clk overlap", both, 0);
        check_n("strobe overlap", multi, 0);

        // halt held from mid-M1, then released
        run_to(157);
        hreq[1] = 1'b1;
        run_to(192);
        check("halt last X3", obs[1], X3Q3_P0);
        tick();
        check("halt entry", obs[1], X3_HALT);
        run_to(200);
        check("halt frozen", obs[1], X3_HALT);
        hreq[1] = 1'b0;
        tick();
        check("halt resume", obs[1], A1_P0);
        run_to(203);
        check("resume q1", obs[1], ev(0, 0, 8'h00, 1, 1, 0, 0, 0));

        // one-sysclk pulse during A2 is ignored
        run_to(209);
        hreq[1] = 1'b1;
        tick();
        hreq[1] = 1'b0;
        run_to(264);
        check("pulse X3", obs[1], X3Q3_P0);
        tick();
        check("pulse no halt", obs[1], A1_P0);

        // asynchronous abort during M2 clk2
        run_to(301);
        check("m22 active", obs[1], ev(0, 1, 8'h10, 1, 1, 0, 0, 0));
        #1 rstn[1] = 1'b0;
        #1 check("async abort", obs[1], RST);
        tick();
        tick();
        check("abort held", obs[1], RST);
        do_release(1);
        run_to(64);
        check("re-poc held", obs[1], X3Q3);
        tick();
        check("re-poc fall", obs[1], A1_P0);

        // halt request held through poc stretch
        hreq[2] = 1'b1;
        do_release(2);
        run_to(32);
        check("poc3 X3 c1", obs[2], X3Q3);
        tick();
        check("poc3 no halt c1", obs[2], Q0);
        run_to(65);
        check("poc3 no halt c2", obs[2], Q0);
        run_to(96);
        check("poc3 X3 c3", obs[2], X3Q3);
        tick();
        check("poc3 fall", obs[2], A1_P0);
        run_to(128);
        check("poc3 X3 c4", obs[2], X3Q3_P0);
        tick();
        check("poc3 halt", obs[2], X3_HALT);
        hreq[2] = 1'b0;
        tick();
        check("poc3 resume", obs[2], A1_P0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
